// File: rtl/timer_device_if.sv
// Bus-side signal bundle between the system bridge and the countdown timer.
// Latency: none; wires only.
// Backpressure: none; the bridge issues single-cycle WE strobes with no stall path.
interface timer_device_if;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DIN;
    logic [31:0] DOUT;
    logic        IRQ;

    // Bridge side drives address/write strobe/data and reads back data and IRQ.
    modport master (
        output Addr,
        output WE,
        output DIN,
        input  DOUT,
        input  IRQ
    );

    // Timer side.
    modport slave (
        input  Addr,
        input  WE,
        input  DIN,
        output DOUT,
        output IRQ
    );
endinterface

// File: rtl/timer_device.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with one-shot or periodic IRQ.
// Latency: IRQ rises max(PRESET,1)*step+2 edges after EN is written; DOUT is combinational on Addr.
// Backpressure: none; writes always accepted. Optional macro TIMER_PRESCALE_EN adds a PRESCALE-cycle step.
module timer_device #(
    parameter int PRESCALE = 4
) (
    input  logic           clk,
    input  logic           reset,
    timer_device_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_e;

    // Register file word indices (byte address bits [3:2]).
    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic        step;

    assign ctrl_en   = ctrl_q[0];
    assign ctrl_mode = ctrl_q[2:1];
    assign ctrl_im   = ctrl_q[3];

`ifdef TIMER_PRESCALE_EN
    // Prescaler counts clk cycles inside CNT; a count step happens only on its wrap.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;

    assign step = (pre_q == PRE_LAST);

    // Prescaler next-state: run only while counting, cleared everywhere else.
    always_comb begin
        pre_d = '0;
        if (state_q == S_CNT && ctrl_en) begin
            pre_d = step ? '0 : pre_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    // Without the prescaler every CNT cycle is a count step; PRESCALE has no effect.
    logic unused_prescale;
    assign unused_prescale = (PRESCALE < 1);
    assign step            = 1'b1;
`endif

    // FSM next-state and register updates; a software CTRL write overrides FSM changes.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            S_IDLE: begin
                if (ctrl_en) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_en) begin
                    // Disabled mid-count: COUNT freezes, no interrupt.
                    state_d = S_IDLE;
                end else if (step) begin
                    if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        // Terminal step also covers PRESET=0 without underflow.
                        count_d    = '0;
                        irq_flag_d = 1'b1;
                        state_d    = S_INT;
                    end
                end
            end
            S_INT: begin
                if (ctrl_mode == 2'b01) begin
                    // Periodic: flag lives for exactly one cycle, then reload.
                    irq_flag_d = 1'b0;
                    state_d    = S_LOAD;
                end else begin
                    // One-shot (and reserved modes): self-disable, flag held until CTRL write.
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.WE) begin
            case (bus.Addr)
                A_CTRL: begin
                    ctrl_d     = bus.DIN[3:0];
                    irq_flag_d = 1'b0;
                end
                A_PRESET: begin
                    preset_d = bus.DIN;
                end
                default: begin
                    // COUNT is read-only; word 3 is reserved.
                end
            endcase
        end
    end

    // State and register file, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // Read mux, combinational on Addr.
    always_comb begin
        bus.DOUT = '0;
        case (bus.Addr)
            A_CTRL:   bus.DOUT = {28'b0, ctrl_q};
            A_PRESET: bus.DOUT = preset_q;
            A_COUNT:  bus.DOUT = count_q;
            default:  bus.DOUT = '0;
        endcase
    end

    // IRQ comes only from registered state, never directly from DIN.
    assign bus.IRQ = irq_flag_q & ctrl_im;

endmodule

// File: tb/tb_timer_device.sv
// Self-checking bench for timer_device: vector table, directed corner sequences, random episodes.
// Expected values come from closed-form timing rules (load at edge 2, step every PS cycles, period L).
// Built with or without TIMER_PRESCALE_EN; the model step size follows the macro.
module tb_timer_device;

`ifdef TIMER_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    timer_device_if bus ();

    timer_device #(.PRESCALE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic        we;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [1:0] a, input logic w, input logic [31:0] d,
                                input logic [31:0] ed, input logic ei);
        vec_t v;
        v.addr = a; v.we = w; v.din = d; v.exp_dout = ed; v.exp_irq = ei;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d actual=0x%08h expected=0x%08h", name, k, act, exp);
        end
    endtask

    // ---------------- reference model (edges k counted from the CTRL write edge) ----------------
    function automatic int period_len(input int p);
        int pe;
        pe = (p < 1) ? 1 : p;
        return pe * PS + 2;
    endfunction

    function automatic logic [31:0] exp_count(input int p, input int mode, input int k);
        int pe, span, j;
        pe   = (p < 1) ? 1 : p;
        span = pe * PS;
        if (k < 2) return 32'd0;
        j = k - 2;
        if (mode == 1) j = j % (span + 2);
        if (j < span) return 32'(p - j / PS);
        return 32'd0;
    endfunction

    function automatic logic exp_irq(input int p, input logic [3:0] c, input int k);
        int l;
        l = period_len(p);
        if (!c[3] || k < l) return 1'b0;
        if (c[2:1] == 2'b01) return ((k % l) == 0);
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_ctrl(input int p, input logic [3:0] c, input int k);
        if (c[2:1] != 2'b01 && k >= period_len(p) + 1) return {28'b0, c & 4'he};
        return {28'b0, c};
    endfunction

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        bus.WE = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.Addr = a;
        bus.WE   = 1'b1;
        bus.DIN  = d;
        @(posedge clk);
        #1;
        bus.WE = 1'b0;
    endtask

    // Observe K edges after a CTRL write, checking every read and IRQ against the model.
    // Random writes to COUNT/reserved words are injected and must be ignored.
    task automatic run_episode(input int p, input logic [3:0] c, input int kmax, output int first_irq);
        int mode;
        logic [1:0] a;
        logic [31:0] e;
        mode      = int'(c[2:1]);
        first_irq = -1;
        for (int k = 1; k <= kmax; k++) begin
            @(posedge clk);
            #1;
            bus.WE  = 1'($urandom_range(0, 1));
            a       = bus.WE ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 3));
            bus.Addr = a;
            bus.DIN = $urandom;
            #1;
            case (a)
                2'd0:    e = exp_ctrl(p, c, k);
                2'd1:    e = 32'(p);
                2'd2:    e = exp_count(p, mode, k);
                default: e = 32'd0;
            endcase
            chk($sformatf("ep_dout_a%0d", a), k, bus.DOUT, e);
            chk("ep_irq", k, {31'b0, bus.IRQ}, {31'b0, exp_irq(p, c, k)});
            if (bus.IRQ && first_irq < 0) first_irq = k;
        end
        bus.WE = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        for (int a = 0; a < 3; a++) begin
            bus.Addr = 2'(a);
            #1;
            chk($sformatf("%s_a%0d", name, a), 0, bus.DOUT, 32'd0);
        end
        chk($sformatf("%s_irq", name), 0, {31'b0, bus.IRQ}, 32'd0);
    endtask

    initial begin
        int fi;
        int p;
        logic [3:0] c;
        logic [31:0] frozen;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.Addr = '0;
        bus.WE   = 1'b0;
        bus.DIN  = '0;

        // ---------- vector table: reset state, ignored writes, one-shot countdown ----------
        add(2'd0, 1'b0, 32'h0,  32'h0, 1'b0);
        add(2'd1, 1'b0, 32'h0,  32'h0, 1'b0);
        add(2'd2, 1'b1, 32'h55, 32'h0, 1'b0);
        add(2'd2, 1'b0, 32'h0,  32'h0, 1'b0);
        add(2'd3, 1'b0, 32'h0,  32'h0, 1'b0);
        add(2'd1, 1'b1, 32'h3,  32'h0, 1'b0);
        add(2'd1, 1'b0, 32'h0,  32'h3, 1'b0);
`ifndef TIMER_PRESCALE_EN
        add(2'd0, 1'b1, 32'h9,  32'h0, 1'b0);  // write edge E0 follows
        add(2'd2, 1'b0, 32'h0,  32'h0, 1'b0);  // k=0
        add(2'd2, 1'b0, 32'h0,  32'h0, 1'b0);  // k=1 (LOAD pending)
        add(2'd2, 1'b0, 32'h0,  32'h3, 1'b0);  // k=2
        add(2'd2, 1'b0, 32'h0,  32'h2, 1'b0);
        add(2'd2, 1'b0, 32'h0,  32'h1, 1'b0);
        add(2'd2, 1'b0, 32'h0,  32'h0, 1'b1);  // k=5: IRQ
        add(2'd0, 1'b1, 32'h0,  32'h8, 1'b1);  // EN self-cleared, IRQ held; clear CTRL
        add(2'd0, 1'b0, 32'h0,  32'h0, 1'b0);  // IRQ dropped
        add(2'd2, 1'b0, 32'h0,  32'h0, 1'b0);
`endif
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            bus.Addr = tbl[i].addr;
            bus.WE   = tbl[i].we;
            bus.DIN  = tbl[i].din;
            #1;
            chk($sformatf("tbl%0d_dout", i), i, bus.DOUT, tbl[i].exp_dout);
            chk($sformatf("tbl%0d_irq", i), i, {31'b0, bus.IRQ}, {31'b0, tbl[i].exp_irq});
        end
        bus.WE = 1'b0;

        // ---------- one-shot latency ----------
        do_reset();
        do_write(2'd1, 32'd3);
        do_write(2'd0, 32'h9);
        run_episode(3, 4'h9, 3 * PS + 6, fi);
        chk("oneshot_latency", 0, 32'(fi), 32'(3 * PS + 2));

        // ---------- periodic: pulses every L cycles for several periods ----------
        do_reset();
        do_write(2'd1, 32'd2);
        do_write(2'd0, 32'hB);
        run_episode(2, 4'hB, 4 * period_len(2) + 1, fi);
        chk("periodic_first_irq", 0, 32'(fi), 32'(2 * PS + 2));

        // ---------- IM=0: no IRQ, then re-enable with IM ----------
        do_reset();
        do_write(2'd1, 32'd5);
        do_write(2'd0, 32'h1);
        run_episode(5, 4'h1, 5 * PS + 4, fi);
        chk("masked_no_irq", 0, {31'b0, (fi >= 0)}, 32'd0);
        do_write(2'd0, 32'h9);
        run_episode(5, 4'h9, 5 * PS + 4, fi);
        chk("restart_latency", 0, 32'(fi), 32'(5 * PS + 2));

        // ---------- clear EN mid-count: COUNT freezes, no IRQ ----------
        do_reset();
        do_write(2'd1, 32'd10);
        do_write(2'd0, 32'h9);
        run_episode(10, 4'h9, 3, fi);
        do_write(2'd0, 32'h8);                   // lands on edge 4
        frozen = exp_count(10, 0, 4);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            bus.Addr = 2'd2;
            #1;
            chk("frozen_count", k, bus.DOUT, frozen);
            chk("frozen_irq", k, {31'b0, bus.IRQ}, 32'd0);
            bus.Addr = 2'd0;
            #1;
            chk("frozen_ctrl", k, bus.DOUT, 32'h8);
        end

        // ---------- reset mid-count ----------
        do_reset();
        do_write(2'd1, 32'd10);
        do_write(2'd0, 32'h9);
        run_episode(10, 4'h9, 5, fi);
        do_reset();
        #1;
        check_all_zero("rst_midcount");

        // ---------- reset while IRQ held in one-shot ----------
        do_write(2'd1, 32'd1);
        do_write(2'd0, 32'h9);
        run_episode(1, 4'h9, period_len(1) + 2, fi);
        chk("pre_rst_irq", 0, {31'b0, bus.IRQ}, 32'd1);
        do_reset();
        #1;
        check_all_zero("rst_int");

        // ---------- randomized episodes ----------
        for (int n = 0; n < 20; n++) begin
            p = $urandom_range(0, 6);
            c = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1};
            do_reset();
            do_write(2'd1, 32'(p));
            do_write(2'd0, {28'b0, c});
            run_episode(p, c, 3 * period_len(p) + 1, fi);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
